// File: rtl/parity_gen_chk.sv
// Parity unit for the UART datapath: TX parity-bit generator and RX serial
// frame checker with sequencing FSM and a saturating parity-error counter.
module parity_gen_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_PAR_BIT,
  output logic                  TX_PAR_VLD,
  input  logic                  RX_START,
  input  logic                  RX_BIT,
  input  logic                  RX_BIT_VLD,
  input  logic                  RX_PAR_VLD,
  input  logic                  ERR_CLR,
  output logic                  RX_BUSY,
  output logic                  CHK_DONE,
  output logic                  PAR_ERR,
  output logic                  SEQ_ERR,
  output logic [ERR_CNT_W-1:0]  ERR_CNT
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  // xr is the XOR reduction of the data word.
  function automatic logic par_rule(input logic xr, input logic [1:0] typ);
    case (typ)
      2'b00:   return xr;
      2'b01:   return ~xr;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic                 tx_par_q, tx_par_d;
  logic                 tx_vld_q;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic                 sh_en_q, sh_en_d;
  logic [1:0]           sh_typ_q, sh_typ_d;
  logic                 chk_done_q, chk_done_d;
  logic                 par_err_q, par_err_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // TX path: one registered result per TX_VALID
  always_comb begin
    tx_par_d = tx_par_q;
    if (TX_VALID) begin
      tx_par_d = PAR_EN ? par_rule(^TX_DATA, PAR_TYP) : 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_par_q <= 1'b0;
      tx_vld_q <= 1'b0;
    end else begin
      tx_par_q <= tx_par_d;
      tx_vld_q <= TX_VALID;
    end
  end

  // RX frame FSM; RX_START outranks RX_PAR_VLD, which outranks RX_BIT_VLD
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sh_en_d    = sh_en_q;
    sh_typ_d   = sh_typ_q;
    chk_done_d = 1'b0;
    par_err_d  = 1'b0;
    seq_err_d  = 1'b0;

    if (RX_START) begin
      state_d  = S_DATA;
      cnt_d    = '0;
      acc_d    = 1'b0;
      sh_en_d  = PAR_EN;
      sh_typ_d = PAR_TYP;
    end else begin
      case (state_q)
        S_DATA: begin
          if (RX_PAR_VLD) begin
            seq_err_d = 1'b1;
            state_d   = S_IDLE;
          end else if (RX_BIT_VLD) begin
            acc_d = acc_q ^ RX_BIT;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              if (sh_en_q) begin
                state_d = S_PARITY;
              end else begin
                state_d    = S_IDLE;
                chk_done_d = 1'b1;
              end
            end
          end
        end
        S_PARITY: begin
          if (RX_PAR_VLD) begin
            chk_done_d = 1'b1;
            par_err_d  = (RX_BIT != par_rule(acc_q, sh_typ_q));
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Error counter sees this cycle's PAR_ERR so both appear after the same edge
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ERR_CLR) begin
      err_cnt_d = par_err_d ? ERR_CNT_W'(1) : '0;
    end else if (par_err_d) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      sh_en_q    <= 1'b0;
      sh_typ_q   <= 2'b00;
      chk_done_q <= 1'b0;
      par_err_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sh_en_q    <= sh_en_d;
      sh_typ_q   <= sh_typ_d;
      chk_done_q <= chk_done_d;
      par_err_q  <= par_err_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign TX_PAR_BIT = tx_par_q;
  assign TX_PAR_VLD = tx_vld_q;
  assign RX_BUSY    = (state_q != S_IDLE);
  assign CHK_DONE   = chk_done_q;
  assign PAR_ERR    = par_err_q;
  assign SEQ_ERR    = seq_err_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Scoreboard bench for parity_gen_chk: a frame-level reference model queues
// expected TX results and RX frame outcomes; a monitor compares them.
module tb_parity_gen_chk;

  localparam int DW  = 8;
  localparam int ECW = 2;

  logic          CLK = 1'b0;
  logic          RST, PAR_EN, TX_VALID, RX_START, RX_BIT, RX_BIT_VLD, RX_PAR_VLD, ERR_CLR;
  logic [1:0]    PAR_TYP;
  logic [DW-1:0] TX_DATA;
  logic          TX_PAR_BIT, TX_PAR_VLD, RX_BUSY, CHK_DONE, PAR_ERR, SEQ_ERR;
  logic [ECW-1:0] ERR_CNT;

  parity_gen_chk #(.DATA_WIDTH(DW), .ERR_CNT_W(ECW)) dut (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_PAR_BIT(TX_PAR_BIT), .TX_PAR_VLD(TX_PAR_VLD),
    .RX_START(RX_START), .RX_BIT(RX_BIT), .RX_BIT_VLD(RX_BIT_VLD), .RX_PAR_VLD(RX_PAR_VLD),
    .ERR_CLR(ERR_CLR), .RX_BUSY(RX_BUSY), .CHK_DONE(CHK_DONE), .PAR_ERR(PAR_ERR),
    .SEQ_ERR(SEQ_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic seq; logic perr; } rx_evt_t;

  logic    tx_q[$];
  rx_evt_t rx_q[$];
  int      n_chk = 0;
  int      n_fail = 0;

  // reference model state (frame level)
  logic m_frame = 1'b0, m_waitpar = 1'b0, m_en = 1'b0;
  logic [1:0] m_typ = 2'b00;
  logic bits_q[$];
  int   m_cnt = 0;
  logic exp_txbit = 1'b0;
  logic exp_busy = 1'b0;

  function automatic logic rule(input int ones, input logic [1:0] typ);
    case (typ)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the effect of the current inputs at the coming rising edge.
  task automatic model_step();
    logic perr;
    int ones;
    perr = 1'b0;
    if (RST) begin
      m_frame = 0; m_waitpar = 0; bits_q.delete(); m_cnt = 0; exp_txbit = 0;
    end else begin
      if (TX_VALID) begin
        exp_txbit = PAR_EN ? rule($countones(TX_DATA), PAR_TYP) : 1'b0;
        tx_q.push_back(exp_txbit);
      end
      if (RX_START) begin
        m_frame = 1; m_waitpar = 0; bits_q.delete(); m_en = PAR_EN; m_typ = PAR_TYP;
      end else if (m_frame && !m_waitpar) begin
        if (RX_PAR_VLD) begin
          rx_q.push_back('{seq: 1'b1, perr: 1'b0});
          m_frame = 0;
        end else if (RX_BIT_VLD) begin
          bits_q.push_back(RX_BIT);
          if (bits_q.size() == DW) begin
            if (m_en) m_waitpar = 1;
            else begin
              rx_q.push_back('{seq: 1'b0, perr: 1'b0});
              m_frame = 0;
            end
          end
        end
      end else if (m_frame && m_waitpar && RX_PAR_VLD) begin
        ones = 0;
        foreach (bits_q[i]) ones += int'(bits_q[i]);
        perr = (RX_BIT != rule(ones, m_typ));
        rx_q.push_back('{seq: 1'b0, perr: perr});
        m_frame = 0; m_waitpar = 0;
      end
      if (ERR_CLR) m_cnt = perr ? 1 : 0;
      else if (perr && m_cnt < (1 << ECW) - 1) m_cnt++;
    end
    exp_busy = m_frame;
  endtask

  // Monitor: sample one time unit after each rising edge
  always @(posedge CLK) begin
    rx_evt_t e;
    logic    t;
    #1;
    chk("tx_vld", int'(TX_PAR_VLD), int'(tx_q.size() > 0));
    if (tx_q.size() > 0) begin
      t = tx_q.pop_front();
      if (TX_PAR_VLD) chk("tx_par_bit_new", int'(TX_PAR_BIT), int'(t));
    end
    chk("tx_par_bit_hold", int'(TX_PAR_BIT), int'(exp_txbit));

    chk("rx_event", int'(CHK_DONE | SEQ_ERR), int'(rx_q.size() > 0));
    if (rx_q.size() > 0) begin
      e = rx_q.pop_front();
      if (CHK_DONE | SEQ_ERR) begin
        chk("chk_done", int'(CHK_DONE), int'(!e.seq));
        chk("seq_err", int'(SEQ_ERR), int'(e.seq));
        chk("par_err", int'(PAR_ERR), int'(e.perr));
      end
    end else begin
      chk("par_err_quiet", int'(PAR_ERR), 0);
    end
    chk("rx_busy", int'(RX_BUSY), int'(exp_busy));
    chk("err_cnt", int'(ERR_CNT), m_cnt);
  end

  task automatic clr_strobes();
    RST = 0; TX_VALID = 0; RX_START = 0; RX_BIT_VLD = 0; RX_PAR_VLD = 0; ERR_CLR = 0;
  endtask

  task automatic tick();
    model_step();
    @(negedge CLK);
    clr_strobes();
  endtask

  task automatic tx(input logic [DW-1:0] d, input logic en, input logic [1:0] typ);
    TX_DATA = d; PAR_EN = en; PAR_TYP = typ; TX_VALID = 1; tick();
    tick();
  endtask

  task automatic rx_start(input logic en, input logic [1:0] typ);
    PAR_EN = en; PAR_TYP = typ; RX_START = 1; tick();
  endtask

  task automatic rx_bits(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      RX_BIT = w[i]; RX_BIT_VLD = 1; tick();
    end
  endtask

  task automatic rx_par(input logic b, input logic clr);
    RX_BIT = b; RX_PAR_VLD = 1; ERR_CLR = clr; tick();
  endtask

  task automatic rx_frame(input logic [DW-1:0] w, input logic [1:0] typ, input logic pb, input logic clr);
    rx_start(1'b1, typ);
    rx_bits(w, DW);
    rx_par(pb, clr);
  endtask

  initial begin
    clr_strobes();
    RST = 1; PAR_EN = 0; PAR_TYP = 0; TX_DATA = 0; RX_BIT = 0;
    model_step();
    @(negedge CLK);
    RST = 1; tick();
    tick();

    // TX: 0xA5 under each parity type, and with parity disabled
    tx(8'hA5, 1, 2'b00);
    tx(8'hA5, 1, 2'b01);
    tx(8'hA5, 1, 2'b10);
    tx(8'hA5, 1, 2'b11);
    tx(8'hA5, 0, 2'b10);
    for (int i = 0; i < 4; i++) begin
      TX_DATA = DW'($urandom); PAR_EN = 1; PAR_TYP = 2'(i); TX_VALID = 1; tick();
    end
    tick();

    // RX: even parity on 0x0F, good then bad parity bit
    rx_frame(8'h0F, 2'b00, 1'b0, 1'b0);
    rx_frame(8'h0F, 2'b00, 1'b1, 1'b0);

    // RX with parity disabled; trailing parity strobe is ignored
    rx_start(1'b0, 2'b00);
    rx_bits(8'h5A, DW);
    rx_par(1'b1, 1'b0);
    tick();

    // Premature parity strobe, then restart from PARITY state
    rx_start(1'b1, 2'b00);
    rx_bits(8'hFF, 5);
    rx_par(1'b0, 1'b0);
    rx_start(1'b1, 2'b01);
    rx_bits(8'h33, DW);
    rx_frame(8'h81, 2'b01, 1'b1, 1'b0);
    rx_frame(8'h00, 2'b10, 1'b0, 1'b0);
    rx_frame(8'h00, 2'b11, 1'b0, 1'b0);

    // Saturation, then clear coincident with another error
    for (int i = 0; i < 5; i++) rx_frame(8'h01, 2'b00, 1'b0, 1'b0);
    rx_frame(8'h01, 2'b00, 1'b0, 1'b1);
    ERR_CLR = 1; tick();

    // Reset mid-frame, then a clean odd-parity frame
    rx_start(1'b1, 2'b00);
    rx_bits(8'hFF, 3);
    TX_DATA = 8'h01; PAR_EN = 1; PAR_TYP = 2'b01; TX_VALID = 1; RST = 1; tick();
    rx_frame(8'h01, 2'b01, 1'b0, 1'b0);
    tick();

    // Randomized traffic with mid-frame config churn
    for (int c = 0; c < 1500; c++) begin
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 2'($urandom);
      TX_DATA    = DW'($urandom);
      TX_VALID   = ($urandom_range(0, 2) == 0);
      RX_BIT     = 1'($urandom);
      RX_START   = ($urandom_range(0, 13) == 0);
      RX_BIT_VLD = ($urandom_range(0, 1) == 0);
      RX_PAR_VLD = m_waitpar ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      ERR_CLR    = ($urandom_range(0, 39) == 0);
      RST        = ($urandom_range(0, 149) == 0);
      tick();
    end
    tick();
    tick();

    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
